hazard_scoreboard: RTL
======================

Name: hazard_scoreboard

Overview:
- Hazard and sequencing controller for the decode stage. It tracks in-flight writers in E/M/W and the single non-pipelined multi-cycle multiplier.
- Generates the decode forwarding selects (fwd_1/fwd_2), bubble insertion, front-end stall and ID/EX enable.
- Arbitrates the multiplier: start, busy, done, and its writeback slot.

Parameters:
- MUL_LAT, 4, cycles from multiplier issue to result valid on mult_out_M; legal range 3..15.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- halt  in  1  syscall halt reached W; freezes all state
- mispredict  in  1  flush the instruction currently in D
- instr_valid_D  in  1  D holds a real instruction
- rs1_D, rs2_D  in  5  source registers
- use_rs1_D, use_rs2_D  in  1  source actually read
- rd_D  in  5  destination register
- rd_we_D  in  1  instruction writes rd
- is_load_D  in  1  load (result available in M only)
- is_mult_D  in  1  multiply (routed to multiplier, not the E/M ALU path)
- fwd_1, fwd_2  out  4  0=regfile, 1=E value, 2=M value, 9=mult_out_M
- insert_bubble_D  out  1  replace the E-bound instruction with a NOP
- stall_FD  out  1  hold PC and IF/ID
- ID_EX_en  out  1  ID/EX register enable
- mult_start  out  1  launch the multiplier this cycle
- mult_busy  out  1  multiplier occupied
- mult_done  out  1  result valid on mult_out_M this cycle
- mult_rd  out  5  destination of the in-flight multiply

Behaviour:
- Internal state:
  - Slots E, M, W, each {v, rd, we, load}.
  - Multiplier tracker {busy, rd, cnt[3:0]}.
- Reset (rst=1 at a clk edge): all slots v=0, busy=0, cnt=0. While rst=1, outputs are forced to fwd=0, insert_bubble_D=0, stall_FD=0, ID_EX_en=1, mult_start=0.
- Pipeline advance, every cycle with halt=0:
  - W<=M, M<=E.
  - E<=D-info if D issues, else a bubble (v=0).
  - A multiply issues into E with we=0.
- Register 0 never causes a hazard or a forward.
- Source match for rsN (N=1,2): applies when use_rsN_D=1 and rsN!=0. Checks are in priority order, youngest first:
  1. busy and mult_rd==rsN: cnt==0 gives fwdN=9; otherwise raise a RAW stall.
  2. E.v, E.we and E.rd==rsN: E.load gives a load-use stall; otherwise fwdN=1.
  3. M.v, M.we and M.rd==rsN: fwdN=2.
  4. Otherwise fwdN=0. W is covered by the regfile's internal forwarding.
- Additional stall causes (instr_valid_D=1 required):
  - Structural: is_mult_D and busy and cnt!=0.
  - WAW: rd_we_D, !is_mult_D, busy and rd_D==mult_rd.
  - Writeback collision: rd_we_D, !is_mult_D, busy and cnt==2. Such an instruction would reach M in the same cycle as mult_done.
- stall = instr_valid_D AND (any cause above). When stall=1:
  - stall_FD=1 and insert_bubble_D=1.
  - ID_EX_en=1, so the bubble is written into ID/EX.
- mispredict=1:
  - insert_bubble_D=1 and the E slot gets a bubble.
  - mult_start=0.
  - stall_FD=0; the front-end redirect owns the PC.
  - An older in-flight multiply continues.
- Issue:
  - Condition: instr_valid_D and !stall and !mispredict and !halt.
  - If is_mult_D, mult_start=1 (combinational). Next edge: busy<=1, cnt<=MUL_LAT-1, mult_rd<=rd_D.
- Multiplier countdown:
  - While busy, cnt decrements each cycle.
  - mult_done = busy && cnt==0, for exactly one cycle; the datapath writes back mult_rd in that cycle.
  - Next edge: busy<=0, unless mult_start reloads it (back-to-back multiplies are allowed when cnt==0).
- halt=1:
  - All state holds.
  - ID_EX_en=0, stall_FD=1, insert_bubble_D=0, mult_start=0.
  - mult_done keeps its current value but cnt does not decrement.
- Outputs are combinational from state and the D inputs. Every registered element resets as listed above.

Test Plan:
- ALU-ALU: add x5 issued, then add x6,x5,x0 in D next cycle -> fwd_1=1, no stall. Two cycles later a consumer of x5 -> fwd_1=2.
- Load-use: lw x7 in E, D reads x7 on rs2 -> stall_FD=1, insert_bubble_D=1 for exactly 1 cycle, then fwd_2=2.
- Multiply RAW, MUL_LAT=4: mul x8 issues at t, consumer of x8 in D -> stalled t+1..t+3; at t+4 mult_done=1, fwd_1=9, issue proceeds; mult_busy=0 at t+5.
- Structural/collision, MUL_LAT=4: mul at t, second mul at t+1 -> stalled until t+4, where it issues back-to-back and mult_busy stays 1. Independent add x9 in D at t+2 (cnt==2) -> 1-cycle stall.
- Flush and x0: mul in D with mispredict=1 -> mult_start=0, mult_busy stays 0. Instruction reading x0 while x0 is in E -> fwd=0, no stall.
- Reset and halt: rst mid-multiply -> next cycle mult_busy=0, all fwd=0, ID_EX_en=1. halt=1 for 3 cycles at cnt=2 -> cnt still 2 afterwards, ID_EX_en=0 throughout.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// Decode-stage hazard bus: D-stage instruction info in, pipeline controls out.
// master: decode/front-end side (drives D info, halt, mispredict).
// slave : hazard_scoreboard (drives forwarding selects, stall/bubble, multiplier status).
interface hazard_scoreboard_if;
   localparam int unsigned REG_W = 5;
   localparam int unsigned FWD_W = 4;

   logic             halt;
   logic             mispredict;
   logic             instr_valid_D;
   logic [REG_W-1:0] rs1_D;
   logic [REG_W-1:0] rs2_D;
   logic             use_rs1_D;
   logic             use_rs2_D;
   logic [REG_W-1:0] rd_D;
   logic             rd_we_D;
   logic             is_load_D;
   logic             is_mult_D;

   logic [FWD_W-1:0] fwd_1;
   logic [FWD_W-1:0] fwd_2;
   logic             insert_bubble_D;
   logic             stall_FD;
   logic             ID_EX_en;
   logic             mult_start;
   logic             mult_busy;
   logic             mult_done;
   logic [REG_W-1:0] mult_rd;

   modport master (
      output halt, mispredict, instr_valid_D, rs1_D, rs2_D, use_rs1_D, use_rs2_D,
             rd_D, rd_we_D, is_load_D, is_mult_D,
      input  fwd_1, fwd_2, insert_bubble_D, stall_FD, ID_EX_en, mult_start,
             mult_busy, mult_done, mult_rd
   );

   modport slave (
      input  halt, mispredict, instr_valid_D, rs1_D, rs2_D, use_rs1_D, use_rs2_D,
             rd_D, rd_we_D, is_load_D, is_mult_D,
      output fwd_1, fwd_2, insert_bubble_D, stall_FD, ID_EX_en, mult_start,
             mult_busy, mult_done, mult_rd
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: tracks E/M writers and the multi-cycle
// multiplier, produces forwarding selects, stall/bubble controls and the
// multiplier start/busy/done handshake.
// Ports: clk, rst (sync, active-high), hs_if (slave side of hazard bus).
// Outputs are combinational from the tracked state and the D-stage inputs.
module hazard_scoreboard #(
   parameter int unsigned MUL_LAT = 4
) (
   input  logic               clk,
   input  logic               rst,
   hazard_scoreboard_if.slave hs_if
);
   localparam int unsigned REG_W = 5;
   localparam int unsigned CNT_W = 4;
   localparam int unsigned FWD_W = 4;

   localparam logic [FWD_W-1:0] FWD_RF   = FWD_W'(0);
   localparam logic [FWD_W-1:0] FWD_E    = FWD_W'(1);
   localparam logic [FWD_W-1:0] FWD_M    = FWD_W'(2);
   localparam logic [FWD_W-1:0] FWD_MULT = FWD_W'(9);

   // W needs no tracking: the regfile bypasses its own write internally.
   logic             r_e_v, r_e_we, r_e_ld;
   logic [REG_W-1:0] r_e_rd;
   logic             r_m_v, r_m_we;
   logic [REG_W-1:0] r_m_rd;
   logic             r_busy;
   logic [REG_W-1:0] r_mult_rd;
   logic [CNT_W-1:0] r_cnt;

   logic [FWD_W-1:0] w_fwd1, w_fwd2;
   logic             w_raw1, w_raw2;
   logic             w_struct, w_waw, w_coll;
   logic             w_stall, w_issue;

   // Youngest-first source resolution: {raw_stall, fwd_sel}.
   function automatic logic [FWD_W:0] f_src(
      input logic             use_rs,
      input logic [REG_W-1:0] rs,
      input logic             busy,
      input logic [REG_W-1:0] mrd,
      input logic [CNT_W-1:0] cnt,
      input logic             ev, ewe, eld,
      input logic [REG_W-1:0] erd,
      input logic             mv, mwe,
      input logic [REG_W-1:0] mrd_slot
   );
      logic [FWD_W:0] res;
      res = {1'b0, FWD_RF};
      if (use_rs && rs != REG_W'(0)) begin
         if (busy && mrd == rs) begin
            res = (cnt == CNT_W'(0)) ? {1'b0, FWD_MULT} : {1'b1, FWD_RF};
         end else if (ev && ewe && erd == rs) begin
            res = eld ? {1'b1, FWD_RF} : {1'b0, FWD_E};
         end else if (mv && mwe && mrd_slot == rs) begin
            res = {1'b0, FWD_M};
         end
      end
      return res;
   endfunction

   // Hazard detection and output generation.
   always_comb begin
      w_fwd1   = FWD_RF;
      w_fwd2   = FWD_RF;
      w_raw1   = 1'b0;
      w_raw2   = 1'b0;
      {w_raw1, w_fwd1} = f_src(hs_if.use_rs1_D, hs_if.rs1_D, r_busy, r_mult_rd, r_cnt,
                               r_e_v, r_e_we, r_e_ld, r_e_rd, r_m_v, r_m_we, r_m_rd);
      {w_raw2, w_fwd2} = f_src(hs_if.use_rs2_D, hs_if.rs2_D, r_busy, r_mult_rd, r_cnt,
                               r_e_v, r_e_we, r_e_ld, r_e_rd, r_m_v, r_m_we, r_m_rd);

      w_struct = hs_if.is_mult_D && r_busy && (r_cnt != CNT_W'(0));
      w_waw    = hs_if.rd_we_D && !hs_if.is_mult_D && r_busy && (hs_if.rd_D == r_mult_rd);
      // Such an ALU op would reach M in the multiplier's writeback cycle.
      w_coll   = hs_if.rd_we_D && !hs_if.is_mult_D && r_busy && (r_cnt == CNT_W'(2));
      w_stall  = hs_if.instr_valid_D && (w_raw1 || w_raw2 || w_struct || w_waw || w_coll);
      w_issue  = hs_if.instr_valid_D && !w_stall && !hs_if.mispredict && !hs_if.halt;

      hs_if.fwd_1           = w_fwd1;
      hs_if.fwd_2           = w_fwd2;
      hs_if.insert_bubble_D = w_stall;
      hs_if.stall_FD        = w_stall;
      hs_if.ID_EX_en        = 1'b1;
      hs_if.mult_start      = w_issue && hs_if.is_mult_D;
      hs_if.mult_busy       = r_busy;
      hs_if.mult_done       = r_busy && (r_cnt == CNT_W'(0));
      hs_if.mult_rd         = r_mult_rd;

      if (hs_if.mispredict) begin
         hs_if.insert_bubble_D = 1'b1;
         hs_if.stall_FD        = 1'b0;
      end
      if (hs_if.halt) begin
         hs_if.insert_bubble_D = 1'b0;
         hs_if.stall_FD        = 1'b1;
         hs_if.ID_EX_en        = 1'b0;
      end
      if (rst) begin
         hs_if.fwd_1           = FWD_RF;
         hs_if.fwd_2           = FWD_RF;
         hs_if.insert_bubble_D = 1'b0;
         hs_if.stall_FD        = 1'b0;
         hs_if.ID_EX_en        = 1'b1;
         hs_if.mult_start      = 1'b0;
      end
   end

   // Pipeline slot tracking and multiplier countdown; halt freezes everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_e_v     <= 1'b0;
         r_e_we    <= 1'b0;
         r_e_ld    <= 1'b0;
         r_e_rd    <= REG_W'(0);
         r_m_v     <= 1'b0;
         r_m_we    <= 1'b0;
         r_m_rd    <= REG_W'(0);
         r_busy    <= 1'b0;
         r_mult_rd <= REG_W'(0);
         r_cnt     <= CNT_W'(0);
      end else if (!hs_if.halt) begin
         r_m_v  <= r_e_v;
         r_m_we <= r_e_we;
         r_m_rd <= r_e_rd;
         r_e_v  <= w_issue;
         r_e_we <= hs_if.rd_we_D && !hs_if.is_mult_D;
         r_e_ld <= hs_if.is_load_D;
         r_e_rd <= hs_if.rd_D;
         if (w_issue && hs_if.is_mult_D) begin
            r_busy    <= 1'b1;
            r_cnt     <= CNT_W'(MUL_LAT - 1);
            r_mult_rd <= hs_if.rd_D;
         end else if (r_busy) begin
            if (r_cnt == CNT_W'(0)) r_busy <= 1'b0;
            else                    r_cnt  <= r_cnt - CNT_W'(1);
         end
      end
   end
endmodule
